muldiv_ctrl: RTL

Sequencer for the execute-stage multi-cycle units: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage, latches operands, drives the clocked multiplier and the iterative divider, and raises the EX stall request until the result is ready. It produces a single HI/LO write bus toward the HI/LO register file and the forwarding network, and it abandons in-flight work on flush.

---
 rtl/muldiv_ctrl_pkg.sv | 32 +++
 rtl/muldiv_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared constants and types for the multiply/divide
// sequencer. Holds the md_op one-hot width and bit positions, the
// stall/divider handshake levels and the sequencer state encoding.
package muldiv_ctrl_pkg;

  localparam int MD_OP_WD = 6;

  // Bit positions inside the one-hot md_op vector {mult, multu, div, divu, mthi, mtlo}
  localparam int MD_MULT  = 5;
  localparam int MD_MULTU = 4;
  localparam int MD_DIV   = 3;
  localparam int MD_DIVU  = 2;
  localparam int MD_MTHI  = 1;
  localparam int MD_MTLO  = 0;

  // Pipeline stall request levels
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Divider handshake levels
  localparam logic DIV_START        = 1'b1;
  localparam logic DIV_STOP         = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: execute-stage sequencer for the multi-cycle HI/LO units.
// Accepts mult/multu/div/divu/mthi/mtlo from EX, latches operands for the
// external multiplier and iterative divider, stalls EX until the result is
// captured, then issues one HI/LO write. Flush abandons in-flight work.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   md_op              one-hot {mult, multu, div, divu, mthi, mtlo}
//   src1, src2         forwarded rs / rt operand values
//   flush              kill the EX instruction and any in-flight work
//   stall_hold         a later stage is stalling; EX cannot retire
//   div_*              divider control, latched operands, result, ready
//   mul_*              multiplier control, latched operands, product
//   stallreq           hold EX and earlier stages (combinational)
//   hi_we/lo_we, *_wdata  HI/LO write bus (strobes combinational)
//   state_dbg          current sequencer state
//
// Handshake: a write is a single-cycle strobe; the HI/LO file samples
// hi_wdata/lo_wdata on the clock edge ending any cycle where the matching
// write enable is high. div_ready is sampled only while a divide runs.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MD_OP_WD-1:0] md_op,
  input  logic [31:0]         src1,
  input  logic [31:0]         src2,
  input  logic                flush,
  input  logic                stall_hold,
  output logic                div_start,
  output logic                div_signed,
  output logic [31:0]         div_opa,
  output logic [31:0]         div_opb,
  output logic                div_annul,
  input  logic [63:0]         div_result,
  input  logic                div_ready,
  output logic                mul_signed,
  output logic [31:0]         mul_opa,
  output logic [31:0]         mul_opb,
  input  logic [63:0]         mul_result,
  output logic                stallreq,
  output logic                hi_we,
  output logic                lo_we,
  output logic [31:0]         hi_wdata,
  output logic [31:0]         lo_wdata,
  output logic [1:0]          state_dbg
);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        mul_signed_q, mul_signed_d;
  logic [31:0] mul_opa_q, mul_opa_d, mul_opb_q, mul_opb_d;
  logic        div_signed_q, div_signed_d;
  logic [31:0] div_opa_q, div_opa_d, div_opb_q, div_opb_d;
  logic        div_start_q, div_start_d;
  logic        div_annul_q, div_annul_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;

  logic is_mul, is_div;
  assign is_mul = md_op[MD_MULT] | md_op[MD_MULTU];
  assign is_div = md_op[MD_DIV]  | md_op[MD_DIVU];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mul_signed_q <= 1'b0;
      mul_opa_q    <= '0;
      mul_opb_q    <= '0;
      div_signed_q <= 1'b0;
      div_opa_q    <= '0;
      div_opb_q    <= '0;
      div_start_q  <= DIV_STOP;
      div_annul_q  <= 1'b0;
      res_hi_q     <= '0;
      res_lo_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_signed_q <= mul_signed_d;
      mul_opa_q    <= mul_opa_d;
      mul_opb_q    <= mul_opb_d;
      div_signed_q <= div_signed_d;
      div_opa_q    <= div_opa_d;
      div_opb_q    <= div_opb_d;
      div_start_q  <= div_start_d;
      div_annul_q  <= div_annul_d;
      res_hi_q     <= res_hi_d;
      res_lo_q     <= res_lo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_signed_d = mul_signed_q;
    mul_opa_d    = mul_opa_q;
    mul_opb_d    = mul_opb_q;
    div_signed_d = div_signed_q;
    div_opa_d    = div_opa_q;
    div_opb_d    = div_opb_q;
    div_start_d  = div_start_q;
    div_annul_d  = 1'b0;
    res_hi_d     = res_hi_q;
    res_lo_d     = res_lo_q;
    stallreq     = NO_STOP;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    hi_wdata     = res_hi_q;
    lo_wdata     = res_lo_q;

    unique case (state_q)
      ST_IDLE: begin
        // mthi/mtlo write straight through from src1 with no stall
        hi_wdata = src1;
        lo_wdata = src1;
        if (!flush) begin
          hi_we = md_op[MD_MTHI];
          lo_we = md_op[MD_MTLO];
          if (is_mul) begin
            mul_opa_d    = src1;
            mul_opb_d    = src2;
            mul_signed_d = md_op[MD_MULT];
            cnt_d        = 6'(MUL_CYCLES - 1);
            state_d      = ST_MUL_BUSY;
            stallreq     = STOP;
          end else if (is_div) begin
            stallreq = STOP;
            if (src2 != 32'd0) begin
              div_opa_d    = src1;
              div_opb_d    = src2;
              div_signed_d = md_op[MD_DIV];
              div_start_d  = DIV_START;
              state_d      = ST_DIV_BUSY;
            end else begin
              // Divide by zero never reaches the divider
              res_hi_d = src1;
              res_lo_d = 32'hFFFF_FFFF;
              state_d  = ST_DONE;
            end
          end
        end
      end
      ST_MUL_BUSY: begin
        stallreq = STOP;
        if (cnt_q == 6'd0) begin
          res_hi_d = mul_result[63:32];
          res_lo_d = mul_result[31:0];
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      ST_DIV_BUSY: begin
        stallreq = STOP;
        if (div_ready == DIV_RESULT_READY) begin
          res_hi_d    = div_result[63:32];
          res_lo_d    = div_result[31:0];
          div_start_d = DIV_STOP;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // md_op is ignored here so the retiring instruction cannot retrigger
        if (!stall_hold && !flush) begin
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d     = ST_IDLE;
      div_start_d = DIV_STOP;
      div_annul_d = (state_q == ST_DIV_BUSY);
    end
  end

  assign div_start  = div_start_q;
  assign div_signed = div_signed_q;
  assign div_opa    = div_opa_q;
  assign div_opb    = div_opb_q;
  assign div_annul  = div_annul_q;
  assign mul_signed = mul_signed_q;
  assign mul_opa    = mul_opa_q;
  assign mul_opb    = mul_opb_q;
  assign state_dbg  = state_q;

endmodule
